// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and types for the return-address-stack controller.
package riscv_pkg;
    localparam int XLEN         = 32;
    localparam int RQ_DEPTH     = 4;
    localparam int RQ_PTR_WIDTH = $clog2(RQ_DEPTH);

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [4:0] REG_RA   = 5'd1;
    localparam logic [4:0] REG_T0   = 5'd5;

    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_PUSH_AND_POP
    } ras_op_t;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction
endpackage

// File: rtl/ras_ctrl_if.sv
// Bus between the RAS controller (master) and the return address stack (slave).
interface ras_ctrl_if #(parameter int XLEN = riscv_pkg::XLEN);
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_return_addr;
    logic [XLEN-1:0] ras_predicted;
    logic            ras_valid;

    modport master (output ras_push, ras_pop, ras_return_addr,
                    input  ras_predicted, ras_valid);
    modport slave  (input  ras_push, ras_pop, ras_return_addr,
                    output ras_predicted, ras_valid);
endinterface

// File: rtl/ret_queue.sv
// FIFO of in-flight return predictions; flush clears it after any same-cycle dequeue.
module ret_queue #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         enq,
    input  logic [W-1:0]                 enq_data,
    input  logic                         deq,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !flush) mem[wr_ptr] <= enq_data;
    end
endmodule

// File: rtl/ras_ctrl.sv
// Drives RAS push/pop from fetch and checks queued return predictions at execute.
// Optional RAS_CTRL_STATS_EN adds saturating return/mispredict counters.
module ras_ctrl #(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int RQ_DEPTH = riscv_pkg::RQ_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [31:0]       if_instr,
    input  logic              flush,
    ras_ctrl_if.master        ras,
    output logic              ret_pred_valid,
    output logic [XLEN-1:0]   ret_pred_target,
    output logic              stall_req,
    input  logic              ex_resolve_valid,
    input  logic [XLEN-1:0]   ex_actual_target,
    output logic              ex_mispredict,
    output logic [XLEN-1:0]   ex_redirect_target
`ifdef RAS_CTRL_STATS_EN
    ,
    output logic [31:0]       stat_returns,
    output logic [31:0]       stat_mispredicts
`endif
);
    import riscv_pkg::*;

    ras_op_t         op;
    logic            is_ret, deq_fire, ret_accept, mis_next;
    logic            q_full, q_empty, head_valid;
    logic [XLEN-1:0] head_target;
    logic [$clog2(RQ_DEPTH+1)-1:0] q_count;
    logic [4:0]      rd, rs1;
    logic            unused_ok;

    assign rd        = if_instr[11:7];
    assign rs1       = if_instr[19:15];
    assign unused_ok = ^{if_instr[31:20], if_instr[14:12], q_count};

    always_comb begin
        op = RAS_NONE;
        if (if_valid && !flush) begin
            if (if_instr[6:0] == OPC_JAL) begin
                if (is_link(rd)) op = RAS_PUSH;
            end else if (if_instr[6:0] == OPC_JALR) begin
                case ({is_link(rd), is_link(rs1)})
                    2'b10:   op = RAS_PUSH;
                    2'b01:   op = RAS_POP;
                    2'b11:   op = (rd == rs1) ? RAS_PUSH : RAS_PUSH_AND_POP;
                    default: op = RAS_NONE;
                endcase
            end
        end
    end

    // A same-cycle resolve frees a slot, so a return on a full queue still goes through.
    assign is_ret     = (op == RAS_POP) || (op == RAS_PUSH_AND_POP);
    assign deq_fire   = ex_resolve_valid && !q_empty;
    assign ret_accept = is_ret && (!q_full || deq_fire);
    assign stall_req  = is_ret && !ret_accept;

    assign ras.ras_push        = (op == RAS_PUSH) || ((op == RAS_PUSH_AND_POP) && ret_accept);
    assign ras.ras_pop         = ret_accept;
    assign ras.ras_return_addr = if_pc + XLEN'(4);
    assign ret_pred_valid      = ret_accept && ras.ras_valid;
    assign ret_pred_target     = ret_accept ? ras.ras_predicted : '0;

    ret_queue #(.W(XLEN+1), .DEPTH(RQ_DEPTH)) u_rq (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .enq      (ret_accept),
        .enq_data ({ras.ras_predicted, ras.ras_valid}),
        .deq      (deq_fire),
        .head     ({head_target, head_valid}),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign mis_next = deq_fire && (!head_valid || (head_target != ex_actual_target));

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mispredict      <= 1'b0;
            ex_redirect_target <= '0;
        end else begin
            ex_mispredict <= mis_next;
            if (deq_fire) ex_redirect_target <= ex_actual_target;
        end
    end

`ifdef RAS_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_returns     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (ret_accept && stat_returns != '1)   stat_returns     <= stat_returns + 32'd1;
            if (mis_next && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif
endmodule
